// File: rtl/seven_stim.sv
`timescale 1ns/1ps
// Purpose: stimulus driver and checker for the seven-state lab FSM `seven`.
//   It steers `seven` into one terminal state (d/e/f/g), checks z1..z3 and keeps pass/fail counters.
// Latency: done is asserted 4 cycles after an accepted start if the shadow is B, or 5 cycles if it is A.
// Backpressure: start is accepted only while busy=0. A start or target change during a run is ignored.
// Ports:
//   clk, reset            clock (rising edge); async active-high reset, the same net that resets `seven`
//   start, target[1:0]    run request; target 0=d 1=e 2=f 3=g, latched on accept
//   z1, z2, z3            outputs observed from `seven`
//   x1, x2, x3            inputs driven into `seven`
//   busy, done, pass      run in progress; 1-cycle completion pulse; result qualified by done
//   err                   sticky flag, set when z disagrees with the shadow model on any cycle
//   pass_cnt, fail_cnt    saturating run counters
module seven_stim #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       target,
  input  logic             z1,
  input  logic             z2,
  input  logic             z3,
  output logic             x1,
  output logic             x2,
  output logic             x3,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  // State encodings used by `seven`.
  localparam logic [2:0] ST_A = 3'b000;
  localparam logic [2:0] ST_B = 3'b001;
  localparam logic [2:0] ST_C = 3'b101;
  localparam logic [2:0] ST_D = 3'b010;
  localparam logic [2:0] ST_E = 3'b100;
  localparam logic [2:0] ST_G = 3'b111;

  // `seven` never holds a state. This drive makes it alternate between A and B while we are idle.
  localparam logic [2:0] X_PARK = 3'b100;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_STEP2,
    S_CHECK
  } drv_t;

  drv_t       drv, drv_nxt;
  logic [2:0] shadow, shadow_nxt;
  logic [1:0] tgt;
  logic [2:0] xv;
  logic [2:0] z_run_exp;
  logic [2:0] z_mon_exp;
  logic       match;

  assign {x1, x2, x3} = xv;
  assign busy         = (drv != S_IDLE);

  // Driver FSM and x decode.
  always_comb begin
    drv_nxt = drv;
    xv      = X_PARK;
    case (drv)
      S_IDLE: begin
        if (start) drv_nxt = S_WAIT;
      end
      S_WAIT: begin
        // Leave A toward B (target d) or toward C (targets e/f/g).
        if (shadow == ST_A) begin
          xv      = {(tgt == 2'd0), 2'b00};
          drv_nxt = S_STEP2;
        end
      end
      S_STEP2: begin
        case (tgt)
          2'd0:    xv = 3'b010;  // B -> D
          2'd1:    xv = 3'b011;  // C -> E
          2'd2:    xv = 3'b001;  // C -> F
          default: xv = 3'b000;  // C -> G
        endcase
        drv_nxt = S_CHECK;
      end
      default: begin
        drv_nxt = S_IDLE;
      end
    endcase
  end

  // Shadow copy of `seven`, advanced with the x value actually driven.
  always_comb begin
    shadow_nxt = ST_A;
    case (shadow)
      ST_A: shadow_nxt = xv[2] ? ST_B : ST_C;
      ST_B: shadow_nxt = xv[1] ? ST_D : ST_A;
      ST_C: begin
        case (xv[1:0])
          2'b11:   shadow_nxt = 3'b100;  // E
          2'b10:   shadow_nxt = ST_A;
          2'b01:   shadow_nxt = 3'b110;  // F
          default: shadow_nxt = ST_G;
        endcase
      end
      default: shadow_nxt = ST_A;
    endcase
  end

  // z expected at the end of a run for the latched target, and z expected every cycle from the shadow.
  always_comb begin
    case (tgt)
      2'd0:    z_run_exp = 3'b100;
      2'd1:    z_run_exp = 3'b010;
      2'd2:    z_run_exp = 3'b000;
      default: z_run_exp = 3'b001;
    endcase
    case (shadow)
      ST_D:    z_mon_exp = 3'b100;
      ST_E:    z_mon_exp = 3'b010;
      ST_G:    z_mon_exp = 3'b001;
      default: z_mon_exp = 3'b000;
    endcase
  end

  assign match = ({z1, z2, z3} == z_run_exp);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drv      <= S_IDLE;
      shadow   <= ST_A;
      tgt      <= 2'd0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err      <= 1'b0;
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else begin
      drv    <= drv_nxt;
      shadow <= shadow_nxt;
      done   <= (drv == S_CHECK);
      if (drv == S_IDLE && start) tgt <= target;
      if (drv == S_CHECK) begin
        pass <= match;
        if (match) begin
          if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_ONE;
        end else begin
          if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_ONE;
        end
      end
      if ({z1, z2, z3} != z_mon_exp) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seven_stim.sv
`timescale 1ns/1ps
// Bench for seven_stim. It holds a behavioural copy of `seven` in lockstep with the DUT.
// Runs push their expected result into a scoreboard queue, and a negedge monitor checks each done pulse.
module tb_seven_stim;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [1:0]       target = 2'd0;
  logic             z1, z2, z3;
  logic             x1, x2, x3;
  logic             busy, done, pass, err;
  logic [CNT_W-1:0] pass_cnt, fail_cnt;

  always #5 clk = ~clk;

  seven_stim #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .target(target),
    .z1(z1), .z2(z2), .z3(z3),
    .x1(x1), .x2(x2), .x3(x3),
    .busy(busy), .done(done), .pass(pass), .err(err),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );

  // Model of `seven`: A=000 B=001 C=101 D=010 E=100 F=110 G=111.
  logic [2:0] st;
  logic       kill_z1 = 1'b0;
  always @(posedge clk or posedge reset) begin
    if (reset) st <= 3'b000;
    else begin
      case (st)
        3'b000: st <= x1 ? 3'b001 : 3'b101;
        3'b001: st <= x2 ? 3'b010 : 3'b000;
        3'b101: st <= ({x2, x3} == 2'b11) ? 3'b100 : ({x2, x3} == 2'b10) ? 3'b000 :
                      ({x2, x3} == 2'b01) ? 3'b110 : 3'b111;
        default: st <= 3'b000;
      endcase
    end
  end
  assign z1 = (st == 3'b010) & ~kill_z1;
  assign z2 = (st == 3'b100);
  assign z3 = (st == 3'b111);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic             pass;
    logic [CNT_W-1:0] pc;
    logic [CNT_W-1:0] fc;
    int               cyc_due;
  } exp_t;
  exp_t sbq[$];

  logic [CNT_W-1:0] epc = '0;
  logic [CNT_W-1:0] efc = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [1:0] x23(input logic [1:0] t);
    case (t)
      2'd0:    return 2'b10;
      2'd1:    return 2'b11;
      2'd2:    return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // Scoreboard monitor.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset && done) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: done=1 with no run outstanding, expected 0 (cycle %0d)", cyc);
      end else begin
        e = sbq.pop_front();
        chk("done_cycle", 32'(cyc), 32'(e.cyc_due));
        chk("pass", 32'(pass), 32'(e.pass));
        chk("pass_cnt_at_done", 32'(pass_cnt), 32'(e.pc));
        chk("fail_cnt_at_done", 32'(fail_cnt), 32'(e.fc));
      end
    end
  end

  // Called at posedge+1 while idle. Waits (bounded) until the model is in B.
  task automatic wait_b();
    bit got;
    got = 0;
    for (int i = 0; i < 4; i++) begin
      if (st == 3'b001) begin
        got = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL wait_b: model never reached B, expected B within 4 cycles");
    end
  endtask

  // Called at posedge+1 with the DUT idle. It returns at posedge+1 of the done cycle.
  // bad corrupts z1 during CHECK. spam raises start with a different target while busy.
  task automatic run(input logic [1:0] t, input bit bad, input bit spam);
    int lat;
    int off;
    logic [2:0] xe;
    lat = (st == 3'b001) ? 4 : 5;
    off = lat - 4;
    if (bad) efc = sat_inc(efc);
    else     epc = sat_inc(epc);
    sbq.push_back('{pass: !bad, pc: epc, fc: efc, cyc_due: cyc + lat});
    start  = 1'b1;
    target = t;
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      start   = spam && (k < lat);
      target  = (spam && (k < lat)) ? ~t : t;
      kill_z1 = bad && (k == 3 + off);
      if (k < lat) begin
        xe = 3'b100;
        if (k == 1 + off)      xe = {(t == 2'd0), 2'b00};
        else if (k == 2 + off) xe = {1'b0, x23(t)};
        chk("x_seq", 32'({x1, x2, x3}), 32'(xe));
        chk("busy_run", 32'(busy), 32'd1);
      end else begin
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", 32'({x1, x2, x3}), 32'b100);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_pass_cnt", 32'(pass_cnt), 32'd0);
    chk("rst_fail_cnt", 32'(fail_cnt), 32'd0);
    reset = 1'b0;

    // Idle parking.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("idle_x", 32'({x1, x2, x3}), 32'b100);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_err", 32'(err), 32'd0);
    end

    // Target d, starting from B.
    wait_b();
    run(2'd0, 1'b0, 1'b0);
    chk("t2_pass_cnt", 32'(pass_cnt), 32'd1);
    chk("t2_err", 32'(err), 32'd0);

    // Back-to-back targets e, f, g. Each run starts on the previous run's done cycle.
    run(2'd1, 1'b0, 1'b0);
    run(2'd2, 1'b0, 1'b0);
    run(2'd3, 1'b0, 1'b0);
    chk("t3_pass_cnt_sat", 32'(pass_cnt), 32'd3);
    chk("t3_fail_cnt", 32'(fail_cnt), 32'd0);

    // Target g from A. This run has one extra WAIT cycle, and start/target toggle while busy.
    chk("t4_model_in_A", 32'(st), 32'b000);
    run(2'd3, 1'b0, 1'b1);
    chk("t4_err", 32'(err), 32'd0);

    // Corrupted z1 in CHECK gives a failing run and sets err, which stays set.
    wait_b();
    run(2'd0, 1'b1, 1'b0);
    chk("t5_fail_cnt", 32'(fail_cnt), 32'd1);
    chk("t5_err", 32'(err), 32'd1);
    run(2'd1, 1'b0, 1'b0);
    run(2'd2, 1'b0, 1'b0);
    chk("t5_err_sticky", 32'(err), 32'd1);

    // Reset during STEP2.
    wait_b();
    start  = 1'b1;
    target = 2'd2;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("t6_step2_x", 32'({x1, x2, x3}), 32'b001);
    reset = 1'b1;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_x", 32'({x1, x2, x3}), 32'b100);
    chk("t6_rst_done", 32'(done), 32'd0);
    chk("t6_rst_pass", 32'(pass), 32'd0);
    chk("t6_rst_err", 32'(err), 32'd0);
    chk("t6_rst_pass_cnt", 32'(pass_cnt), 32'd0);
    chk("t6_rst_fail_cnt", 32'(fail_cnt), 32'd0);
    epc = '0;
    efc = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    wait_b();
    run(2'd1, 1'b0, 1'b0);
    chk("t6_err_after", 32'(err), 32'd0);
    run(2'd0, 1'b0, 1'b0);
    run(2'd1, 1'b0, 1'b0);
    run(2'd2, 1'b0, 1'b0);
    run(2'd3, 1'b0, 1'b0);
    chk("t6_pass_cnt_sat", 32'(pass_cnt), 32'd3);
    chk("t6_fail_cnt", 32'(fail_cnt), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
